// File: rtl/binary_to_bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Build option: BCD_LEADING_BLANK_EN (leading-zero blanking, used by binary_to_bcd).
package binary_to_bcd_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        FINISH  = 2'd2
    } state_t;

    localparam int          DEF_IN_WIDTH   = 10;
    localparam int          DEF_DIGITS     = 4;
    localparam logic [3:0]  BCD_BLANK      = 4'hF;
    localparam logic [3:0]  BCD_ADJ_THRESH = 4'd5;

endpackage

// File: rtl/binary_to_bcd_bcd_digit_adjust.sv
// Double-dabble nibble correction: adds 3 to any digit of 5 or more before the shift.
module bcd_digit_adjust
    import binary_to_bcd_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);

    // 4-bit wrap is harmless: a valid BCD digit never exceeds 9, so the sum stays <= 12.
    assign digit_o = (digit_i >= BCD_ADJ_THRESH) ? digit_i + 4'd3 : digit_i;

endmodule

// File: rtl/binary_to_bcd.sv
// Sequential shift-and-add-3 converter: one bit per clock, IN_WIDTH+2 cycles per result.
// Build option: define BCD_LEADING_BLANK_EN to replace leading zero digits with BCD_BLANK.
module binary_to_bcd
    import binary_to_bcd_pkg::*;
#(
    parameter int IN_WIDTH = DEF_IN_WIDTH,
    parameter int DIGITS   = DEF_DIGITS
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [IN_WIDTH-1:0]   bin_i,
    output logic [4*DIGITS-1:0]   bcdout_o,
    output logic                  done_o
);

    localparam int CNT_W = $clog2(IN_WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IN_WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t                 state_q;
    logic [IN_WIDTH-1:0]    bin_sh_q;
    logic [4*DIGITS-1:0]    acc_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [4*DIGITS-1:0]    bcdout_q;
    logic                   done_q;

    logic [4*DIGITS-1:0]    acc_adj;
    logic [4*DIGITS-1:0]    acc_d;
    logic [IN_WIDTH-1:0]    bin_sh_d;
    logic [4*DIGITS-1:0]    bcdout_d;
    logic                   unused_carry;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_adj
            bcd_digit_adjust u_adj (
                .digit_i (acc_q[4*gi +: 4]),
                .digit_o (acc_adj[4*gi +: 4])
            );
        end
    endgenerate

    // The bit shifted out of acc is always zero given 10^DIGITS > 2^IN_WIDTH - 1.
    assign {unused_carry, acc_d, bin_sh_d} = {acc_adj, bin_sh_q, 1'b0};

`ifdef BCD_LEADING_BLANK_EN
    always_comb begin
        logic leading;
        bcdout_d = acc_q;
        leading  = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            if (leading && (acc_q[4*k +: 4] == 4'd0)) begin
                bcdout_d[4*k +: 4] = BCD_BLANK;
            end else begin
                leading = 1'b0;
            end
        end
    end
`else
    assign bcdout_d = acc_q;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            bin_sh_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            bcdout_q <= '0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        bin_sh_q <= bin_i;
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        state_q  <= CONVERT;
                    end
                end
                CONVERT: begin
                    done_q   <= 1'b0;
                    acc_q    <= acc_d;
                    bin_sh_q <= bin_sh_d;
                    cnt_q    <= cnt_q + CNT_ONE;
                    if (cnt_q == CNT_LAST) begin
                        state_q <= FINISH;
                    end
                end
                FINISH: begin
                    bcdout_q <= bcdout_d;
                    done_q   <= 1'b1;
                    state_q  <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bcdout_o = bcdout_q;
    assign done_o   = done_q;

endmodule

// File: tb/tb_binary_to_bcd.sv
// Self-checking bench for binary_to_bcd: vector table, hand sequences and random values vs. a decimal model.
module tb_binary_to_bcd;

    logic        clk;
    logic        rst;
    logic        start;
    logic [9:0]  bin;
    logic [15:0] bcdout;
    logic        done;

    int total = 0;
    int bad   = 0;
    logic [15:0] prev;
    bit hold_bad;

    binary_to_bcd dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .start_i  (start),
        .bin_i    (bin),
        .bcdout_o (bcdout),
        .done_o   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [9:0]  b;
        logic [15:0] exp;
    } vec_t;

    function automatic logic [15:0] model(input int v);
        logic [15:0] r;
        int x;
        x = v;
        for (int k = 0; k < 4; k++) begin
            r[4*k +: 4] = 4'(x % 10);
            x = x / 10;
        end
`ifdef BCD_LEADING_BLANK_EN
        for (int k = 3; k >= 1; k--) begin
            if (r[4*k +: 4] != 4'd0) break;
            r[4*k +: 4] = 4'hF;
        end
`endif
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Waits (bounded) for DONE, counting negedges; flags any BCDOUT change before DONE.
    task automatic wait_done(output int n);
        n = 0;
        hold_bad = 1'b0;
        do begin
            @(negedge clk);
            n++;
            if (!done && bcdout !== prev) hold_bad = 1'b1;
        end while (!done && n < 40);
    endtask

    task automatic convert(input string nm, input logic [9:0] b, input logic [15:0] exp,
                           input logic [9:0] b_after);
        int n;
        bin = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bin = b_after;
        wait_done(n);
        chk({nm, "_latency"}, n + 1, 12);
        chk({nm, "_hold"}, hold_bad, 0);
        chk({nm, "_value"}, bcdout, exp);
        $display("conv %s bin=%0d bcdout=%h exp=%h cycles=%0d", nm, b, bcdout, exp, n + 1);
        prev = bcdout;
        @(negedge clk);
        chk({nm, "_pulse"}, done, 0);
    endtask

    vec_t vecs[$];

    initial begin
        int n;
        int pulses;
        logic [9:0] r;

`ifdef BCD_LEADING_BLANK_EN
        vecs.push_back('{10'd7,    16'hFFF7});
        vecs.push_back('{10'd0,    16'hFFF0});
        vecs.push_back('{10'd1000, 16'h1000});
        vecs.push_back('{10'd105,  16'hF105});
        vecs.push_back('{10'd1023, 16'h1023});
`else
        vecs.push_back('{10'd1023, 16'h1023});
        vecs.push_back('{10'd512,  16'h0512});
        vecs.push_back('{10'd0,    16'h0000});
        vecs.push_back('{10'd999,  16'h0999});
        vecs.push_back('{10'd7,    16'h0007});
`endif

        rst = 1'b1;
        start = 1'b0;
        bin = '0;
        prev = '0;
        #13;
        chk("reset_bcdout", bcdout, 16'h0000);
        chk("reset_done", done, 0);
        @(negedge clk);
        rst = 1'b0;

        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        chk("idle_no_done", pulses, 0);
        chk("idle_bcdout", bcdout, 16'h0000);
        $display("idle 20 cycles pulses=%0d bcdout=%h", pulses, bcdout);

        foreach (vecs[i]) begin
            convert($sformatf("vec%0d", i), vecs[i].b, vecs[i].exp, vecs[i].b);
        end

        // BIN changes right after capture must be ignored.
`ifdef BCD_LEADING_BLANK_EN
        convert("stable", 10'd345, 16'hF345, 10'd678);
`else
        convert("stable", 10'd345, 16'h0345, 10'd678);
`endif

        // Free-running with START held high.
        bin = 10'd100;
        start = 1'b1;
        wait_done(n);
        chk("free_first_lat", n, 12);
        chk("free_first_val", bcdout, model(100));
        prev = bcdout;
        wait_done(n);
        chk("free_period", n, 12);
        chk("free_second_val", bcdout, model(100));
        $display("free bin=100 bcdout=%h period=%0d", bcdout, n);
        prev = bcdout;
        bin = 10'd101;
        wait_done(n);
        chk("free_change_period", n, 12);
        chk("free_change_val", bcdout, model(101));
        $display("free bin=101 bcdout=%h period=%0d", bcdout, n);
        prev = bcdout;
        start = 1'b0;
        @(negedge clk);
        chk("free_stop_pulse", done, 0);

        // Asynchronous reset in the middle of a conversion.
        bin = 10'd300;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midreset_bcdout", bcdout, 16'h0000);
        chk("midreset_done", done, 0);
        $display("midreset bcdout=%h done=%0d", bcdout, done);
        @(negedge clk);
        rst = 1'b0;
        prev = 16'h0000;
        convert("after_reset", 10'd42, model(42), 10'd42);

        for (int i = 0; i < 20; i++) begin
            r = 10'($urandom_range(0, 1023));
            convert($sformatf("rand%0d", i), r, model(int'(r)), 10'($urandom_range(0, 1023)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
